// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   Command/data parser sitting behind the SPI slave byte interface. Each
//   SS-delimited frame is one command byte followed by data bytes:
//     command bit7 = 1 write, 0 read; bits[3:0] = start address; bits[6:4] unused.
//   Holds a 16 x 8-bit register bank. Register 0 is the read-only ID_VALUE.
//   Writes and reads auto-increment the address, wrapping 15 -> 0.
//
//   Byte handshake: rxValid is a one-cycle pulse qualifying rx. There is no
//   backpressure, so every pulse is consumed in the cycle it arrives. The
//   resulting tx byte is visible on the following cycle. The byte interface
//   samples tx no earlier than two cycles after rxValid.
//
// Ports
//   sysClk    system clock, all logic on the rising edge
//   usrReset  synchronous active-high reset
//   SS        raw SPI slave select, active-low, asynchronous to sysClk
//   rxValid   one-cycle pulse, rx holds a received byte
//   rx        received byte
//   tx        next byte for the byte interface to shift out
//   regs      flat register image, bits [8k+7:8k] = register k
//   wrStrobe  one-cycle pulse per accepted register write
//   wrAddr    address of that write
//   wrData    data of that write
module spi_reg_bank #(
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter logic [7:0] IDLE_TX  = 8'h00
) (
    input  logic         sysClk,
    input  logic         usrReset,
    input  logic         SS,
    input  logic         rxValid,
    input  logic [7:0]   rx,
    output logic [7:0]   tx,
    output logic [127:0] regs,
    output logic         wrStrobe,
    output logic [3:0]   wrAddr,
    output logic [7:0]   wrData
);

    typedef enum logic [1:0] {
        ST_CMD = 2'd0,
        ST_WR  = 2'd1,
        ST_RD  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] addr;
    logic [7:0] reg_mem [1:15];

    // SS synchroniser plus one extra stage for rising-edge detection.
    // All stages idle high so that reset never fabricates a frame end.
    logic ss_meta;
    logic ss_sync;
    logic ss_sync_d;
    logic ss_end;

    assign ss_end = ss_sync & ~ss_sync_d;

    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_sync_d <= 1'b1;
            state     <= ST_CMD;
            addr      <= 4'd0;
            wrStrobe  <= 1'b0;
            wrAddr    <= 4'd0;
            wrData    <= 8'h00;
            for (int k = 1; k < 16; k++) begin
                reg_mem[k] <= 8'h00;
            end
        end else begin
            ss_meta   <= SS;
            ss_sync   <= ss_meta;
            ss_sync_d <= ss_sync;
            wrStrobe  <= 1'b0;

            if (rxValid) begin
                unique case (state)
                    ST_CMD: begin
                        addr  <= rx[3:0];
                        state <= rx[7] ? ST_WR : ST_RD;
                    end
                    ST_WR: begin
                        // Register 0 is read-only: the byte is consumed
                        // and the address still advances, but no strobe.
                        if (addr != 4'd0) begin
                            reg_mem[addr] <= rx;
                            wrStrobe      <= 1'b1;
                            wrAddr        <= addr;
                            wrData        <= rx;
                        end
                        addr <= addr + 4'd1;
                    end
                    ST_RD: begin
                        // Received byte is filler; only the address advances.
                        addr <= addr + 4'd1;
                    end
                    default: state <= ST_CMD;
                endcase
            end

            // Frame end wins over the state update above, but a byte that
            // arrived in the same cycle has already been processed.
            if (ss_end) begin
                state <= ST_CMD;
            end
        end
    end

    always_comb begin
        regs[7:0] = ID_VALUE;
        for (int k = 1; k < 16; k++) begin
            regs[8*k +: 8] = reg_mem[k];
        end
    end

    always_comb begin
        tx = IDLE_TX;
        if (state == ST_RD) begin
            tx = (addr == 4'd0) ? ID_VALUE : reg_mem[addr];
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed scenarios with literal expectations, then
// randomized frames. A frame-level model (command, start address, byte count)
// predicts tx, the register image and the write port every cycle.
module tb_spi_reg_bank;

    logic         clk;
    logic         usrReset;
    logic         SS;
    logic         rxValid;
    logic [7:0]   rx;
    logic [7:0]   tx;
    logic [127:0] regs;
    logic         wrStrobe;
    logic [3:0]   wrAddr;
    logic [7:0]   wrData;

    int tests_run;
    int tests_failed;

    spi_reg_bank dut (
        .sysClk   (clk),
        .usrReset (usrReset),
        .SS       (SS),
        .rxValid  (rxValid),
        .rx       (rx),
        .tx       (tx),
        .regs     (regs),
        .wrStrobe (wrStrobe),
        .wrAddr   (wrAddr),
        .wrData   (wrData)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_regs [16];
    bit         m_ok;
    bit         m_has_cmd;
    bit         m_write;
    logic [3:0] m_start;
    int         m_count;
    bit         m_strobe;
    logic [3:0] m_waddr;
    logic [7:0] m_wdata;
    bit [2:0]   ss_hist;   // SS as sampled 1, 2 and 3 edges ago
    bit         m_ss_end;
    logic [3:0] m_a;

    function automatic logic [3:0] frame_addr(input logic [3:0] start, input int count);
        return 4'((int'(start) + count) % 16);
    endfunction

    function automatic logic [7:0] exp_tx();
        logic [3:0] a;
        if (!m_has_cmd || m_write) return 8'h00;
        a = frame_addr(m_start, m_count);
        return (a == 4'd0) ? 8'hA5 : m_regs[a];
    endfunction

    function automatic logic [127:0] exp_image();
        logic [127:0] img;
        img = '0;
        img[7:0] = 8'hA5;
        for (int k = 1; k < 16; k++) img[8*k +: 8] = m_regs[k];
        return img;
    endfunction

    always @(posedge clk) begin
        if (usrReset) begin
            for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
            m_has_cmd = 0;
            m_write   = 0;
            m_start   = 4'd0;
            m_count   = 0;
            m_strobe  = 0;
            m_waddr   = 4'd0;
            m_wdata   = 8'h00;
            ss_hist   = 3'b111;
            m_ok      = 1;
        end else begin
            // A rise of SS is seen by the parser two edges after it is sampled.
            m_ss_end = ss_hist[1] && !ss_hist[2];
            m_strobe = 0;
            if (rxValid) begin
                if (!m_has_cmd) begin
                    m_has_cmd = 1;
                    m_write   = rx[7];
                    m_start   = rx[3:0];
                    m_count   = 0;
                end else begin
                    m_a = frame_addr(m_start, m_count);
                    if (m_write && m_a != 4'd0) begin
                        m_regs[m_a] = rx;
                        m_strobe    = 1;
                        m_waddr     = m_a;
                        m_wdata     = rx;
                    end
                    m_count++;
                end
            end
            if (m_ss_end) m_has_cmd = 0;
            ss_hist = {ss_hist[1:0], SS};
        end
    end

    // ---------------- per-cycle compare + strobe scoreboard ----------------
    logic [11:0] strobe_q [$];

    always @(negedge clk) begin
        if (m_ok) begin
            check("tx", 128'(tx), 128'(exp_tx()));
            check("regs", regs, exp_image());
            check("wrStrobe", 128'(wrStrobe), 128'(m_strobe));
            check("wrAddr", 128'(wrAddr), 128'(m_waddr));
            check("wrData", 128'(wrData), 128'(m_wdata));
        end
        if (wrStrobe === 1'b1) strobe_q.push_back({wrAddr, wrData});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ss_low();
        SS = 1'b0;
        repeat (3) tick();
    endtask

    task automatic ss_high();
        SS = 1'b1;
        repeat (4) tick();
    endtask

    // Sends one byte; t is tx as seen the cycle after rxValid.
    task automatic send(input logic [7:0] b, output logic [7:0] t);
        rxValid = 1'b1;
        rx      = b;
        tick();
        rxValid = 1'b0;
        t       = tx;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    logic [7:0]  t;
    logic [11:0] s;
    logic [7:0]  exp_rd [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_ok     = 0;
        usrReset = 1'b1;
        SS       = 1'b1;
        rxValid  = 1'b0;
        rx       = 8'h00;
        tick();
        tick();
        usrReset = 1'b0;

        // Reset state
        check("reset_regs", regs, {120'h0, 8'hA5});
        check("reset_tx", 128'(tx), 128'h00);
        check("reset_strobe", 128'(wrStrobe), 128'h0);
        check("reset_wraddr", 128'(wrAddr), 128'h0);

        // Burst write 3..5
        strobe_q.delete();
        ss_low();
        send(8'h83, t); check("bw_tx_cmd", 128'(t), 128'h00);
        send(8'h11, t); check("bw_tx_0", 128'(t), 128'h00);
        send(8'h22, t); check("bw_tx_1", 128'(t), 128'h00);
        send(8'h33, t); check("bw_tx_2", 128'(t), 128'h00);
        ss_high();
        check("bw_reg3", 128'(regs[31:24]), 128'h11);
        check("bw_reg4", 128'(regs[39:32]), 128'h22);
        check("bw_reg5", 128'(regs[47:40]), 128'h33);
        check("bw_strobe_count", 128'(strobe_q.size()), 128'd3);
        if (strobe_q.size() == 3) begin
            check("bw_strobe0", 128'(strobe_q[0]), 128'h311);
            check("bw_strobe1", 128'(strobe_q[1]), 128'h422);
            check("bw_strobe2", 128'(strobe_q[2]), 128'h533);
        end

        // Burst read 3..6
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h00;
        ss_low();
        send(8'h03, t); check("br_tx0", 128'(t), 128'(exp_rd[0]));
        for (int i = 1; i < 4; i++) begin
            send(8'($urandom_range(0, 255)), t);
            check("br_tx", 128'(t), 128'(exp_rd[i]));
        end
        ss_high();

        // Wrap in a write burst: 15 written, 0 discarded
        strobe_q.delete();
        ss_low();
        send(8'h8F, t);
        send(8'h77, t);
        send(8'h99, t);
        ss_high();
        check("wrap_reg15", 128'(regs[127:120]), 128'h77);
        check("wrap_reg0", 128'(regs[7:0]), 128'hA5);
        check("wrap_strobe_count", 128'(strobe_q.size()), 128'd1);
        if (strobe_q.size() == 1) check("wrap_strobe", 128'(strobe_q[0]), 128'hF77);

        // Wrap in a read burst returns the ID
        ss_low();
        send(8'h0F, t); check("wrap_rd0", 128'(t), 128'h77);
        send(8'h00, t); check("wrap_rd1", 128'(t), 128'hA5);
        send(8'h00, t);
        ss_high();

        // SS deasserted mid write burst; next frame byte is a command
        ss_low();
        send(8'h82, t);
        send(8'h44, t);
        ss_high();
        ss_low();
        send(8'h02, t); check("fb_read_reg2", 128'(t), 128'h44);
        ss_high();

        // rxValid coincident with the frame end while writing
        strobe_q.delete();
        ss_low();
        send(8'h88, t);
        SS = 1'b1;
        tick();
        tick();
        rxValid = 1'b1;
        rx      = 8'h66;
        tick();
        rxValid = 1'b0;
        repeat (3) tick();
        check("same_cycle_reg8", 128'(regs[71:64]), 128'h66);
        check("same_cycle_strobe", 128'(strobe_q.size()), 128'd1);
        ss_low();
        send(8'h08, t); check("same_cycle_next_cmd", 128'(t), 128'h66);
        ss_high();

        // Reset in the middle of a read frame, SS kept low
        strobe_q.delete();
        ss_low();
        send(8'h03, t);
        send(8'h00, t);
        usrReset = 1'b1;
        tick();
        usrReset = 1'b0;
        tick();
        send(8'h84, t);
        send(8'h5A, t);
        check("rst_mid_reg4", 128'(regs[39:32]), 128'h5A);
        check("rst_mid_reg3", 128'(regs[31:24]), 128'h00);
        check("rst_mid_strobe_count", 128'(strobe_q.size()), 128'd1);
        if (strobe_q.size() == 1) check("rst_mid_strobe", 128'(strobe_q[0]), 128'h45A);
        ss_high();

        // Randomized frames checked by the per-cycle model
        for (int f = 0; f < 60; f++) begin
            int nbytes;
            ss_low();
            nbytes = $urandom_range(1, 8);
            for (int b = 0; b < nbytes; b++) begin
                send(8'($urandom), t);
                repeat ($urandom_range(0, 2)) tick();
            end
            if ($urandom_range(0, 3) == 0) begin
                // frame end landing on a byte
                SS = 1'b1;
                tick();
                tick();
                rxValid = 1'b1;
                rx      = 8'($urandom);
                tick();
                rxValid = 1'b0;
                repeat ($urandom_range(2, 4)) tick();
            end else begin
                SS = 1'b1;
                repeat ($urandom_range(4, 6)) tick();
            end
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
